// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
// The ALUOP_* codes are also consumed by the ALU decoder.
package mc_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_AND   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b100;
  localparam logic [ALUOP_W-1:0] ALUOP_XOR   = 3'b101;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX, S_RTYPEWB,
    S_BEQEX, S_BNEEX, S_ADDIEX, S_ANDIEX, S_ORIEX, S_XORIEX, S_IMMWB, S_JEX
  } state_t;

  typedef struct packed {
    logic               pcwrite;
    logic               branch;
    logic               bne;
    logic               irwrite;
    logic               memwrite;
    logic               regwrite;
    logic               iord;
    logic               memtoreg;
    logic               regdst;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic               immext;
    logic [1:0]         pcsrc;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_word_t;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_J: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_main_outdec.sv
// Moore output decode: maps the current control state to the full control word.
module mc_main_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = ALUOP_ADD;
      end
      // Branch target is computed speculatively into ALUOut here.
      S_DECODE: begin
        ctrl.alusrcb = 2'b11;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = (state == S_BEQEX);
        ctrl.bne     = (state == S_BNEEX);
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ANDIEX, S_ORIEX, S_XORIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.immext  = 1'b1;
        ctrl.aluop   = (state == S_ANDIEX) ? ALUOP_AND :
                       (state == S_ORIEX)  ? ALUOP_OR  : ALUOP_XOR;
      end
      S_IMMWB: ctrl.regwrite = 1'b1;
      S_JEX: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsrc   = 2'b10;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multi-cycle MIPS core: state register, next-state
// sequencing, and reset/zero gating of the architectural write enables.
module mc_main_fsm
  import mc_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  output logic               pcen,
  output logic               irwrite,
  output logic               memwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               immext,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal
);

  state_t     state;
  ctrl_word_t ctrl;

  // Asynchronous reset abandons any partial instruction and restarts at FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_RTYPEEX;
            OP_BEQ:       state <= S_BEQEX;
            OP_BNE:       state <= S_BNEEX;
            OP_ADDI:      state <= S_ADDIEX;
            OP_ANDI:      state <= S_ANDIEX;
            OP_ORI:       state <= S_ORIEX;
            OP_XORI:      state <= S_XORIEX;
            OP_J:         state <= S_JEX;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:  state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   state <= S_MEMWB;
        S_RTYPEEX: state <= S_RTYPEWB;
        S_ADDIEX, S_ANDIEX, S_ORIEX, S_XORIEX: state <= S_IMMWB;
        default:   state <= S_FETCH;
      endcase
    end
  end

  mc_main_outdec u_outdec (
    .state (state),
    .ctrl  (ctrl)
  );

  // zero only matters when branch/bne are set, i.e. in BEQEX/BNEEX.
  assign pcen     = reset & (ctrl.pcwrite | (ctrl.branch & zero) | (ctrl.bne & ~zero));
  assign irwrite  = reset & ctrl.irwrite;
  assign memwrite = reset & ctrl.memwrite;
  assign regwrite = reset & ctrl.regwrite;
  assign iord     = ctrl.iord;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign immext   = ctrl.immext;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign illegal  = (state == S_DECODE) & ~op_supported(op);

endmodule
